// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path.
// Latency: none (types, constants and a helper function only).
// Backpressure: none.
package rv32i_ctrl_pkg;

   // Base opcodes understood by the core
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Immediate generator format select; values must match the immediate generator
   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_S    = 3'd5
   } imm_type_e;

   // Controller states, exported on state_o for debug
   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_e;

   // Register-file write-back source
   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   // Next-PC source
   typedef enum logic {
      PC_PLUS4 = 1'b0,
      PC_ALU   = 1'b1
   } pc_sel_e;

   // Instruction class; CLS_NONE marks an opcode the core does not implement
   typedef enum logic [3:0] {
      CLS_NONE, CLS_OP, CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
      CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_FENCE, CLS_SYSTEM
   } cls_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;

   // Immediate format implied by an instruction class
   function automatic imm_type_e cls_imm_type(input cls_e cls);
      case (cls)
         CLS_OP_IMM, CLS_LOAD, CLS_JALR: return IMM_I;
         CLS_BRANCH:                     return IMM_B;
         CLS_LUI, CLS_AUIPC:             return IMM_U;
         CLS_JAL:                        return IMM_J;
         CLS_STORE:                      return IMM_S;
         default:                        return IMM_NONE;
      endcase
   endfunction

endpackage

// File: rtl/rv32i_opdecode.sv
// Maps a 7-bit opcode to instruction class, immediate format and illegal flag.
// Latency: purely combinational.
// Backpressure: none.
module rv32i_opdecode
   import rv32i_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output cls_e       o_cls,
   output imm_type_e  o_imm_type,
   output logic       o_illegal
);

   // Opcode to class lookup; SYSTEM is recognised but not executable here
   always_comb begin
      o_cls = CLS_NONE;
      case (i_opcode)
         OPC_OP:     o_cls = CLS_OP;
         OPC_OP_IMM: o_cls = CLS_OP_IMM;
         OPC_LOAD:   o_cls = CLS_LOAD;
         OPC_STORE:  o_cls = CLS_STORE;
         OPC_BRANCH: o_cls = CLS_BRANCH;
         OPC_JAL:    o_cls = CLS_JAL;
         OPC_JALR:   o_cls = CLS_JALR;
         OPC_LUI:    o_cls = CLS_LUI;
         OPC_AUIPC:  o_cls = CLS_AUIPC;
         OPC_FENCE:  o_cls = CLS_FENCE;
         OPC_SYSTEM: o_cls = CLS_SYSTEM;
         default:    o_cls = CLS_NONE;
      endcase
   end

   assign o_imm_type = cls_imm_type(o_cls);
   assign o_illegal  = (o_cls == CLS_NONE) || (o_cls == CLS_SYSTEM);

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH, DECODE, EXEC, (MEM), WB; halts in TRAP.
// Latency: 4 cycles per instruction with zero-wait acks, 5 for loads/stores.
// Backpressure: waits in FETCH/MEM for imem_ack/dmem_ack; traps after MEM_TIMEOUT cycles.
module rv32i_mc_ctrl
   import rv32i_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] ir_opcode,
   input  logic [2:0] ir_funct3,
   input  logic       ir_funct7b5,
   input  logic       br_taken,
   output logic       imem_req,
   input  logic       imem_ack,
   output logic       dmem_req,
   output logic       dmem_we,
   input  logic       dmem_ack,
   output logic       ir_we,
   output logic [2:0] imm_type,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic [3:0] alu_op,
   output logic       rf_we,
   output logic [1:0] wb_sel,
   output logic       pc_we,
   output logic       pc_sel,
   output logic       trap,
   output logic [2:0] state_o
);

   // A zero timeout still needs a 1-bit counter to keep the logic well formed
   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_e           r_state;
   state_e           w_next;
   cls_e             r_cls;
   imm_type_e        r_imm;
   logic             r_br;
   logic [CNT_W-1:0] r_cnt;

   cls_e             w_cls;
   imm_type_e        w_imm;
   logic             w_illegal;
   logic             w_waiting;
   logic             w_ack;
   logic             w_timeout;

   rv32i_opdecode u_opdecode (
      .i_opcode   (ir_opcode),
      .o_cls      (w_cls),
      .o_imm_type (w_imm),
      .o_illegal  (w_illegal)
   );

   assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM);
   assign w_ack     = (r_state == ST_FETCH) ? imem_ack : dmem_ack;
   // An ack in the last allowed cycle suppresses the timeout
   assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && !w_ack && (r_cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RESET;
      else        r_state <= w_next;
   end

   // Class/immediate latched at end of DECODE, branch outcome at end of EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cls <= CLS_NONE;
         r_imm <= IMM_NONE;
         r_br  <= 1'b0;
      end else begin
         if (r_state == ST_DECODE) begin
            r_cls <= w_cls;
            r_imm <= w_imm;
         end
         if (r_state == ST_EXEC) r_br <= br_taken;
      end
   end

   // Wait-cycle counter: counts un-acked FETCH/MEM cycles, zero everywhere else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_cnt <= '0;
      else if (w_waiting && !w_ack) r_cnt <= r_cnt + CNT_W'(1);
      else                       r_cnt <= '0;
   end

   // Next-state selection
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_RESET:  w_next = ST_FETCH;
         ST_FETCH:  if (imem_ack) w_next = ST_DECODE;
                    else if (w_timeout) w_next = ST_TRAP;
         ST_DECODE: w_next = w_illegal ? ST_TRAP : ST_EXEC;
         ST_EXEC:   w_next = ((r_cls == CLS_LOAD) || (r_cls == CLS_STORE)) ? ST_MEM : ST_WB;
         ST_MEM:    if (dmem_ack) w_next = ST_WB;
                    else if (w_timeout) w_next = ST_TRAP;
         ST_WB:     w_next = ST_FETCH;
         ST_TRAP:   w_next = ST_TRAP;
         default:   w_next = ST_TRAP;
      endcase
   end

   // Datapath controls decoded from state, latched class and acks
   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      imm_type  = IMM_NONE;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = ALU_ADD;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      trap      = 1'b0;
      case (r_state)
         ST_FETCH: begin
            imem_req = 1'b1;
            ir_we    = imem_ack;
         end
         ST_EXEC: begin
            imm_type  = r_imm;
            alu_a_sel = (r_cls == CLS_AUIPC) || (r_cls == CLS_JAL) || (r_cls == CLS_BRANCH);
            // Branches compute pc+imm as the target, so only OP uses rs2
            alu_b_sel = (r_cls != CLS_OP);
            case (r_cls)
               CLS_OP:     alu_op = {ir_funct7b5, ir_funct3};
               // Only SRLI/SRAI carry an operation bit in IR[30]; elsewhere it is immediate data
               CLS_OP_IMM: alu_op = {(ir_funct3 == 3'b101) && ir_funct7b5, ir_funct3};
               default:    alu_op = ALU_ADD;
            endcase
         end
         ST_MEM: begin
            imm_type = r_imm;
            dmem_req = 1'b1;
            dmem_we  = (r_cls == CLS_STORE);
         end
         ST_WB: begin
            imm_type = r_imm;
            pc_we    = 1'b1;
            if ((r_cls == CLS_JAL) || (r_cls == CLS_JALR) || ((r_cls == CLS_BRANCH) && r_br))
               pc_sel = PC_ALU;
            rf_we = !((r_cls == CLS_STORE) || (r_cls == CLS_BRANCH) || (r_cls == CLS_FENCE));
            case (r_cls)
               CLS_LOAD:          wb_sel = WB_MEM;
               CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
               CLS_LUI:           wb_sel = WB_IMM;
               default:           wb_sel = WB_ALU;
            endcase
         end
         ST_TRAP: trap = 1'b1;
         default: ;
      endcase
   end

   assign state_o = r_state;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Bench for rv32i_mc_ctrl: table vectors, hand-written corner sequences, random instruction stream.
// Latency: n/a.
// Backpressure: drives imem_ack/dmem_ack with chosen delays, including timeouts.
module tb_rv32i_mc_ctrl;

   localparam int T = 4;

   // Expected/observed output bundle, state first
   typedef struct packed {
      logic [2:0] st;
      logic       trap;
      logic       imem_req;
      logic       ir_we;
      logic       dmem_req;
      logic       dmem_we;
      logic [2:0] imm;
      logic       a_sel;
      logic       b_sel;
      logic [3:0] alu_op;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       pc_we;
      logic       pc_sel;
   } out_t;

   typedef struct packed {
      logic ia;
      logic da;
      logic br;
      out_t exp;
   } tr_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       br;
      int         fd;
      int         md;
      logic [2:0] x_imm;
      logic       x_a;
      logic       x_b;
      logic [3:0] x_aluop;
      logic       x_rf;
      logic [1:0] x_wb;
      logic       x_pcsel;
      logic       x_mem;
      logic       x_dwe;
   } vec_t;

   localparam int K_ILL = 0, K_OP = 1, K_OPIMM = 2, K_LOAD = 3, K_STORE = 4, K_BRANCH = 5,
                  K_JAL = 6, K_JALR = 7, K_LUI = 8, K_AUIPC = 9, K_FENCE = 10, K_SYS = 11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] ir_opcode = '0;
   logic [2:0] ir_funct3 = '0;
   logic       ir_funct7b5 = 1'b0;
   logic       br_taken = 1'b0;
   logic       imem_ack = 1'b0;
   logic       dmem_ack = 1'b0;
   logic       imem_req, dmem_req, dmem_we, ir_we, alu_a_sel, alu_b_sel;
   logic       rf_we, pc_we, pc_sel, trap;
   logic [2:0] imm_type, state_o;
   logic [3:0] alu_op;
   logic [1:0] wb_sel;

   out_t got;
   out_t cap_exec, cap_mem, cap_wb;
   tr_t  q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rv32i_mc_ctrl #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .ir_funct3(ir_funct3),
      .ir_funct7b5(ir_funct7b5), .br_taken(br_taken), .imem_req(imem_req),
      .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .ir_we(ir_we), .imm_type(imm_type), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
      .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
      .trap(trap), .state_o(state_o)
   );

   assign got = {state_o, trap, imem_req, ir_we, dmem_req, dmem_we, imm_type,
                 alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, pc_we, pc_sel};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int kind_of(input logic [6:0] op);
      case (op)
         7'b0110011: return K_OP;
         7'b0010011: return K_OPIMM;
         7'b0000011: return K_LOAD;
         7'b0100011: return K_STORE;
         7'b1100011: return K_BRANCH;
         7'b1101111: return K_JAL;
         7'b1100111: return K_JALR;
         7'b0110111: return K_LUI;
         7'b0010111: return K_AUIPC;
         7'b0001111: return K_FENCE;
         7'b1110011: return K_SYS;
         default:    return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] imm_of(input int k);
      case (k)
         K_OPIMM, K_LOAD, K_JALR: return 3'd1;
         K_BRANCH:                return 3'd2;
         K_LUI, K_AUIPC:          return 3'd3;
         K_JAL:                   return 3'd4;
         K_STORE:                 return 3'd5;
         default:                 return 3'd0;
      endcase
   endfunction

   function automatic out_t blank(input logic [2:0] st);
      out_t o;
      o = '0;
      o.st = st;
      return o;
   endfunction

   // Builds the full per-cycle trace of one instruction given fetch/mem ack delays
   task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic br, input int fd, input int md, output bit trapped);
      int   k;
      out_t o;
      tr_t  e;
      k = kind_of(op);
      trapped = 0;
      for (int c = 0; c <= fd; c++) begin
         if (c == T) begin trapped = 1; break; end
         o = blank(3'd1);
         o.imem_req = 1'b1;
         e.ia = (c == fd);
         o.ir_we = e.ia;
         e.da = 1'($urandom);
         e.br = 1'($urandom);
         e.exp = o;
         q.push_back(e);
      end
      if (!trapped) begin
         e.ia = 1'($urandom); e.da = 1'($urandom); e.br = 1'($urandom);
         e.exp = blank(3'd2);
         q.push_back(e);
         if (k == K_ILL || k == K_SYS) trapped = 1;
      end
      if (!trapped) begin
         o = blank(3'd3);
         o.imm = imm_of(k);
         o.a_sel = (k == K_AUIPC || k == K_JAL || k == K_BRANCH);
         o.b_sel = (k != K_OP);
         if (k == K_OP || (k == K_OPIMM && f3 == 3'b101)) o.alu_op = {f7, f3};
         else if (k == K_OPIMM) o.alu_op = {1'b0, f3};
         e.ia = 1'($urandom); e.da = 1'($urandom); e.br = br;
         e.exp = o;
         q.push_back(e);
         if (k == K_LOAD || k == K_STORE) begin
            for (int c = 0; c <= md; c++) begin
               if (c == T) begin trapped = 1; break; end
               o = blank(3'd4);
               o.imm = imm_of(k);
               o.dmem_req = 1'b1;
               o.dmem_we = (k == K_STORE);
               e.da = (c == md);
               e.ia = 1'($urandom);
               e.br = 1'($urandom);
               e.exp = o;
               q.push_back(e);
            end
         end
         if (!trapped) begin
            o = blank(3'd5);
            o.imm = imm_of(k);
            o.pc_we = 1'b1;
            o.pc_sel = (k == K_JAL || k == K_JALR || (k == K_BRANCH && br));
            o.rf_we = !(k == K_STORE || k == K_BRANCH || k == K_FENCE);
            o.wb_sel = (k == K_LOAD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 :
                       (k == K_LUI) ? 2'd3 : 2'd0;
            e.ia = 1'($urandom); e.da = 1'($urandom); e.br = 1'($urandom);
            e.exp = o;
            q.push_back(e);
         end
      end
      if (trapped) begin
         for (int c = 0; c < 3; c++) begin
            o = blank(3'd6);
            o.trap = 1'b1;
            e.ia = 1'($urandom); e.da = 1'($urandom); e.br = 1'($urandom);
            e.exp = o;
            q.push_back(e);
         end
      end
   endtask

   // Applies up to 'limit' trace cycles, comparing every cycle
   task automatic run_trace(input int limit);
      for (int i = 0; i < q.size() && i < limit; i++) begin
         @(posedge clk);
         #1;
         imem_ack = q[i].ia;
         dmem_ack = q[i].da;
         br_taken = q[i].br;
         @(negedge clk);
         chk($sformatf("trace op=%b cyc%0d", ir_opcode, i), 32'(got), 32'(q[i].exp));
         if (q[i].exp.st == 3'd3) cap_exec = got;
         if (q[i].exp.st == 3'd4) cap_mem = got;
         if (q[i].exp.st == 3'd5) cap_wb = got;
      end
      q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_ack = 1'b1; dmem_ack = 1'b1; br_taken = 1'b1;
      #1;
      chk("reset_outputs", 32'(got), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_release", 32'(got), 32'd0);
   endtask

   task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic br, input int fd, input int md);
      bit tr;
      ir_opcode = op; ir_funct3 = f3; ir_funct7b5 = f7;
      cap_exec = '0; cap_mem = '0; cap_wb = '0;
      build(op, f3, f7, br, fd, md, tr);
      run_trace(1000);
      if (tr) do_reset();
   endtask

   function automatic int pick_delay();
      int r;
      r = $urandom_range(0, 11);
      return (r < 10) ? (r % 4) : (r - 6);
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      vec_t       vt[12];
      logic [6:0] legal[10];
      logic [2:0] exp_st[5];
      int         n;
      bit         tr;

      vt[0]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 3'd0, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{7'b0010011, 3'b101, 1'b1, 1'b0, 2, 0, 3'd1, 1'b0, 1'b1, 4'b1101, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 3'd1, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{7'b0000011, 3'b010, 1'b1, 1'b0, 1, 3, 3'd1, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
      vt[4]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 3'd5, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
      vt[5]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3'd2, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 3'd2, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{7'b1101111, 3'b111, 1'b1, 1'b0, 0, 0, 3'd4, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0, 3'd1, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
      vt[9]  = '{7'b0110111, 3'b101, 1'b1, 1'b0, 0, 0, 3'd3, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0};
      vt[10] = '{7'b0010111, 3'b110, 1'b0, 1'b0, 0, 0, 3'd3, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
      vt[11] = '{7'b0001111, 3'b000, 1'b0, 1'b0, 3, 0, 3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

      legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};

      do_reset();

      // Table vectors, back to back without intervening reset
      for (int i = 0; i < 12; i++) begin
         do_instr(vt[i].op, vt[i].f3, vt[i].f7, vt[i].br, vt[i].fd, vt[i].md);
         chk($sformatf("tbl%0d_exec", i), 32'({cap_exec.imm, cap_exec.a_sel, cap_exec.b_sel, cap_exec.alu_op}),
             32'({vt[i].x_imm, vt[i].x_a, vt[i].x_b, vt[i].x_aluop}));
         chk($sformatf("tbl%0d_wb", i), 32'({cap_wb.imm, cap_wb.rf_we, cap_wb.wb_sel, cap_wb.pc_sel, cap_wb.pc_we}),
             32'({vt[i].x_imm, vt[i].x_rf, vt[i].x_wb, vt[i].x_pcsel, 1'b1}));
         if (vt[i].x_mem)
            chk($sformatf("tbl%0d_mem", i), 32'({cap_mem.dmem_req, cap_mem.dmem_we}), 32'({1'b1, vt[i].x_dwe}));
      end

      // ADD with imem_ack tied high: FETCH, DECODE, EXEC, WB, then FETCH on cycle 5
      do_reset();
      exp_st = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
      ir_opcode = 7'b0110011; ir_funct3 = 3'b000; ir_funct7b5 = 1'b1;
      imem_ack = 1'b1; dmem_ack = 1'b0; br_taken = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("add_seq_state%0d", c), 32'(state_o), 32'(exp_st[c]));
      end

      // Fetch timeout: exactly T FETCH cycles, then TRAP held
      do_reset();
      imem_ack = 1'b0;
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         @(negedge clk);
         if (state_o == 3'd1) n++;
         else break;
      end
      chk("tmo_fetch_cycles", 32'(n), 32'(T));
      chk("tmo_trap", 32'({state_o, trap}), 32'({3'd6, 1'b1}));
      imem_ack = 1'b1; dmem_ack = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("trap_held", 32'({state_o, trap}), 32'({3'd6, 1'b1}));
      #2 rst_n = 1'b0;
      #1 chk("rst_in_trap", 32'(got), 32'd0);
      do_reset();

      // Ack on the last allowed fetch cycle wins over the timeout
      do_instr(7'b0110011, 3'b111, 1'b0, 1'b0, T - 1, 0);
      // Illegal opcode traps after DECODE
      do_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
      // Data-side timeout
      do_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, T);

      // Reset asserted mid-MEM drops the request at once
      ir_opcode = 7'b0000011; ir_funct3 = 3'b010; ir_funct7b5 = 1'b0;
      build(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, tr);
      run_trace(4);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_mem", 32'(got), 32'd0);
      do_reset();

      // Random instruction stream
      for (int i = 0; i < 200; i++) begin
         int         r;
         logic [6:0] op;
         r = $urandom_range(0, 19);
         if (r < 2)       op = 7'($urandom);
         else if (r == 2) op = 7'b1110011;
         else             op = legal[$urandom_range(0, 9)];
         do_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), pick_delay(), pick_delay());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
